imem_load_ctrl: RTL

Controller that owns the 64-word instruction memory's single read port and its write port. After reset it streams a program image into the memory over a valid/ready loader interface while holding the core stalled, then zero-fills the unused words. It then passes the core's fetch address through to the memory and steals single cycles for debug read-back. It sits between the single-cycle core's PC/fetch path, the memory array and the boot/debug host.

---
 rtl/imem_load_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: boot-loads a program image, zero-fills the tail,
// then muxes the read port between the core fetch path and single-cycle debug reads.
module imem_load_ctrl #(
   parameter int          DEPTH     = 64,
   parameter int          AW        = 6,
   parameter bit          BOOT_LOAD = 1'b1,
   parameter logic [31:0] NOP       = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   input  logic [31:0]   fetch_addr,
   output logic [31:0]   fetch_data,
   output logic          core_stall,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic          dbg_ack,
   output logic [31:0]   dbg_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic [AW-1:0] mem_raddr,
   input  logic [31:0]   mem_rdata,
   output logic          load_done,
   output logic [AW:0]   load_count,
   output logic          err_overflow
);

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_ZFILL = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DBG   = 2'd3;

   localparam logic [1:0]    S_RESET  = BOOT_LOAD ? S_LOAD : S_RUN;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [1:0]    state;
   logic [AW-1:0] wptr;
   logic          fetch_unused;

   // Only the word-index bits of the byte PC select an instruction.
   assign fetch_unused = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      ld_ready   = (state == S_LOAD) & ~load_start;
      core_stall = (state != S_RUN);
      mem_we     = 1'b0;
      mem_waddr  = wptr;
      mem_wdata  = '0;
      mem_raddr  = fetch_addr[AW+1:2];
      fetch_data = NOP;
      case (state)
         S_LOAD: begin
            mem_we    = ld_valid & ld_ready & rst_n;
            mem_wdata = ld_data;
         end
         S_ZFILL: mem_we     = ~load_start & rst_n;
         S_RUN:   fetch_data = mem_rdata;
         S_DBG:   mem_raddr  = dbg_addr;
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all updates land together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_RESET;
         wptr         <= '0;
         load_count   <= '0;
         load_done    <= 1'b0;
         err_overflow <= 1'b0;
         dbg_ack      <= 1'b0;
         dbg_rdata    <= '0;
      end else begin
         dbg_ack <= 1'b0;
         case (state)
            S_LOAD: begin
               if (load_start) begin
                  wptr       <= '0;
                  load_count <= '0;
               end else if (ld_valid && ld_ready) begin
                  wptr       <= wptr + 1'b1;
                  load_count <= load_count + 1'b1;
                  if (wptr == LAST_IDX) begin
                     state     <= S_RUN;
                     load_done <= 1'b1;
                     if (!ld_last) err_overflow <= 1'b1;
                  end else if (ld_last) begin
                     state <= S_ZFILL;
                  end
               end
            end
            S_ZFILL: begin
               if (load_start) begin
                  state      <= S_LOAD;
                  wptr       <= '0;
                  load_count <= '0;
               end else begin
                  wptr <= wptr + 1'b1;
                  if (wptr == LAST_IDX) begin
                     state     <= S_RUN;
                     load_done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               // dbg_ack is high exactly in the RUN cycle after DBG, which doubles as
               // the guaranteed fetch-progress cycle before another debug steal.
               if (load_start) begin
                  state        <= S_LOAD;
                  wptr         <= '0;
                  load_count   <= '0;
                  load_done    <= 1'b0;
                  err_overflow <= 1'b0;
               end else if (dbg_req && !dbg_ack) begin
                  state <= S_DBG;
               end
            end
            S_DBG: begin
               dbg_rdata <= mem_rdata;
               dbg_ack   <= 1'b1;
               state     <= S_RUN;
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule
